// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encoding, line geometry and word-select helper for the data cache
package dcache_pkg;

  localparam int WORD_W         = 32;
  localparam int OFFSET_W       = 2;
  localparam int WORDS_PER_LINE = 1 << OFFSET_W;
  localparam int BLOCK_W        = WORD_W * WORDS_PER_LINE;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_MISS = 2'd1;
  localparam logic [1:0] ST_WR_THRU = 2'd2;

  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0]  blk,
                                                   input logic [OFFSET_W-1:0] off);
    return blk[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/tag/data storage: combinational lookup, line refill and single-word update
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  index,
  input  logic [TAG_W-1:0]    tag,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                fill_en,
  input  logic [BLOCK_W-1:0]  fill_data,
  input  logic                word_wr,
  input  logic [WORD_W-1:0]   word_data,
  output logic                hit,
  output logic [WORD_W-1:0]   rdata
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tags [LINES];
  logic [BLOCK_W-1:0] data [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[index] <= 1'b1;
    end
  end

  // Tag and data contents are left unreset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[index] <= tag;
      data[index] <= fill_data;
    end else if (word_wr) begin
      data[index][offset*WORD_W +: WORD_W] <= word_data;
    end
  end

  assign hit   = valid[index] && (tags[index] == tag);
  assign rdata = block_word(data[index], offset);

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - write-through, no-write-allocate direct-mapped data cache controller with memory watchdog
// Optional read hit/miss counters enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int INDEX_W     = 5,
  parameter int MEM_LAT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [WORD_W-1:0]  cpu_wdata,
  output logic [WORD_W-1:0]  cpu_rdata,
  output logic               cpu_stall,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WORD_W-1:0]  mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic               mem_err,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WD_W  = $clog2(MEM_LAT_MAX + 1);

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            hit;
  logic            fill_en;
  logic            word_wr;

  dcache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W]),
    .tag       (cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W]),
    .offset    (cpu_addr[OFFSET_W-1:0]),
    .fill_en   (fill_en),
    .fill_data (mem_rdata),
    .word_wr   (word_wr),
    .word_data (cpu_wdata),
    .hit       (hit),
    .rdata     (cpu_rdata)
  );

  assign wd_expire = (state != ST_IDLE) && (wd_cnt == WD_W'(MEM_LAT_MAX - 1));

  // Outputs are gated by rst_n so a reset mid-transaction drops requests at once.
  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_en   = 1'b0;
    word_wr   = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (cpu_wr) begin
            cpu_stall = 1'b1;
            word_wr   = hit;
            state_nxt = ST_WR_THRU;
          end else if (cpu_rd && !hit) begin
            cpu_stall = 1'b1;
            state_nxt = ST_RD_MISS;
          end
        end
        ST_RD_MISS: begin
          mem_rd    = 1'b1;
          mem_addr  = {cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          cpu_stall = 1'b1;
          if (mem_ready) begin
            fill_en   = 1'b1;
            state_nxt = ST_IDLE;
          end else if (wd_expire) begin
            cpu_stall = 1'b0;
            state_nxt = ST_IDLE;
          end
        end
        ST_WR_THRU: begin
          mem_wr    = 1'b1;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          cpu_stall = 1'b1;
          if (mem_ready || wd_expire) begin
            cpu_stall = 1'b0;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wd_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= (state == ST_IDLE) ? '0 : wd_cnt + 1'b1;
      if (wd_expire && !mem_ready) begin
        mem_err <= 1'b1;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic retry;

  // The hit that follows a refill is the stalled load replaying, not a new access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      retry    <= 1'b0;
    end else begin
      retry <= fill_en;
      if (state == ST_IDLE && cpu_rd && !cpu_wr) begin
        if (!hit) begin
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end else if (!retry) begin
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl with a word memory model and shadow tag model
module tb_dcache_ctrl;

  localparam int ADDR_W      = 10;
  localparam int INDEX_W     = 5;
  localparam int MEM_LAT_MAX = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cpu_rd, cpu_wr;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_stall, mem_rd, mem_wr, mem_ready, mem_err;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic [15:0]  hit_cnt, miss_cnt;

  dcache_ctrl #(
    .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .MEM_LAT_MAX(MEM_LAT_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_err(mem_err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n_hit = 0;
  int          n_miss = 0;
  logic [31:0] mem [1024];
  logic        mv [32];
  logic [2:0]  mt [32];
  logic [31:0] exp_q [$];

  function automatic logic [4:0] idx_of(input logic [9:0] a);
    return a[6:2];
  endfunction

  function automatic logic [2:0] tag_of(input logic [9:0] a);
    return a[9:7];
  endfunction

  function automatic logic model_hit(input logic [9:0] a);
    return mv[idx_of(a)] && (mt[idx_of(a)] == tag_of(a));
  endfunction

  function automatic logic [127:0] block_of(input logic [9:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    n_hit = 0;
    n_miss = 0;
  endtask

  task automatic do_load(input logic [9:0] a, input int lat);
    logic        exp_miss, saw_rd, bad_addr, bad_bus, done;
    logic [9:0]  bad_val;
    logic [31:0] exp_d;
    int          cyc, busy;
    exp_miss = !model_hit(a);
    exp_q.push_back(mem[a]);
    if (exp_miss) n_miss++; else n_hit++;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
    cyc = 0; busy = 0; saw_rd = 0; bad_addr = 0; bad_bus = 0; done = 0; bad_val = '0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      if (mem_rd && mem_wr) bad_bus = 1'b1;
      if (mem_rd) begin
        saw_rd = 1'b1;
        if (mem_addr !== {a[9:2], 2'b00}) begin bad_addr = 1'b1; bad_val = mem_addr; end
        if (busy == lat) begin mem_ready = 1'b1; mem_rdata = block_of(a); end
        busy++;
      end
      #1;
      if (!cpu_stall) begin
        done = 1'b1;
        exp_d = exp_q.pop_front();
        checks++;
        if (cpu_rdata !== exp_d) begin
          errors++; $display("FAIL load_data @%h: got %h expected %h", a, cpu_rdata, exp_d);
        end
      end else begin
        @(posedge clk); #1; mem_ready = 1'b0; cyc++;
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; void'(exp_q.pop_front());
      $display("FAIL load_timeout @%h: stall still %b expected 0", a, cpu_stall);
    end
    checks++;
    if (saw_rd !== exp_miss) begin
      errors++; $display("FAIL load_miss @%h: mem_rd seen %b expected %b", a, saw_rd, exp_miss);
    end
    checks++;
    if (cyc !== (exp_miss ? lat + 2 : 0)) begin
      errors++; $display("FAIL load_latency @%h: got %0d expected %0d", a, cyc, exp_miss ? lat + 2 : 0);
    end
    checks++;
    if (bad_addr !== 1'b0 || bad_bus !== 1'b0) begin
      errors++; $display("FAIL load_mem_bus @%h: mem_addr %h expected %h, rd&wr overlap %b", a, bad_val, {a[9:2], 2'b00}, bad_bus);
    end
    if (exp_miss) begin mv[idx_of(a)] = 1'b1; mt[idx_of(a)] = tag_of(a); end
    @(posedge clk); #1;
    cpu_rd = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_store(input logic [9:0] a, input logic [31:0] d, input int lat, input bit both);
    logic        done, saw_wr, bad_bus, bad_rd;
    logic [9:0]  got_a;
    logic [31:0] got_d;
    int          cyc, busy;
    mem[a] = d;
    cpu_wr = 1'b1; cpu_rd = both; cpu_addr = a; cpu_wdata = d;
    cyc = 0; busy = 0; done = 0; saw_wr = 0; bad_bus = 0; bad_rd = 0; got_a = '0; got_d = '0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      if (mem_rd) bad_rd = 1'b1;
      if (mem_wr) begin
        saw_wr = 1'b1;
        if (mem_addr !== a || mem_wdata !== d) begin bad_bus = 1'b1; got_a = mem_addr; got_d = mem_wdata; end
        if (busy == lat) mem_ready = 1'b1;
        busy++;
      end
      #1;
      if (!cpu_stall) done = 1'b1;
      else begin @(posedge clk); #1; mem_ready = 1'b0; cyc++; end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL store_timeout @%h: stall still %b expected 0", a, cpu_stall);
    end
    checks++;
    if (cyc !== lat + 1) begin
      errors++; $display("FAIL store_latency @%h: got %0d expected %0d", a, cyc, lat + 1);
    end
    checks++;
    if (saw_wr !== 1'b1 || bad_bus !== 1'b0) begin
      errors++; $display("FAIL store_bus @%h: mem_wr %b addr %h data %h expected addr %h data %h", a, saw_wr, got_a, got_d, a, d);
    end
    checks++;
    if (bad_rd !== 1'b0) begin
      errors++; $display("FAIL store_no_rd @%h: mem_rd seen %b expected 0", a, bad_rd);
    end
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h004; cpu_wdata = 32'hFFFF_FFFF;
    mem_ready = 1'b1; mem_rdata = '1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
    checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 000", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", hit_cnt, miss_cnt); end
    cpu_rd = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk); rst_n = 1'b1;
    clear_model();
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss_fill();
    do_load(10'h004, 0);
    do_load(10'h004, 0);
    do_load(10'h007, 2);
  endtask

  task automatic test_store_hit();
    do_store(10'h005, 32'h1234_5678, 1, 1'b0);
    do_load(10'h005, 0);
  endtask

  task automatic test_store_no_allocate();
    do_store(10'h100, 32'hCAFE_F00D, 0, 1'b0);
    do_load(10'h100, 1);
  endtask

  task automatic test_conflict();
    do_load(10'h004, 0);
    do_load(10'h084, 1);
    do_load(10'h004, 0);
  endtask

  task automatic test_rd_wr_both();
    do_store(10'h006, 32'h0BAD_F00D, 0, 1'b1);
    do_load(10'h006, 0);
  endtask

  task automatic test_watchdog();
    int   cnt;
    logic dropped;
    n_miss++;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h2A8;
    cnt = 0; dropped = 1'b0;
    for (int i = 0; i < 40 && !dropped; i++) begin
      @(negedge clk);
      if (mem_rd) cnt++;
      if (!cpu_stall) dropped = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (dropped !== 1'b1 || cnt !== MEM_LAT_MAX) begin
      errors++; $display("FAIL watchdog_cycles: stall dropped %b after %0d mem_rd cycles expected %0d", dropped, cnt, MEM_LAT_MAX);
    end
    @(posedge clk); #1; cpu_rd = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b1 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL watchdog_err: mem_err %b mem_rd %b expected 1 0", mem_err, mem_rd);
    end
    @(posedge clk); #1;
    do_load(10'h2A8, 0);
    checks++;
    if (mem_err !== 1'b1) begin errors++; $display("FAIL watchdog_sticky: got %b expected 1", mem_err); end
  endtask

  task automatic test_random();
    int         t, x, o, lat;
    logic [9:0] a;
    for (int i = 0; i < 100; i++) begin
      t = $urandom_range(0, 3); x = $urandom_range(0, 3); o = $urandom_range(0, 3);
      a = 10'((t << 7) | (x << 2) | o);
      lat = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 6) do_load(a, lat);
      else do_store(a, $urandom, lat, $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic test_stats();
    int exp_h, exp_m;
`ifdef DCACHE_STATS_EN
    exp_h = n_hit; exp_m = n_miss;
`else
    exp_h = 0; exp_m = 0;
`endif
    @(negedge clk);
    checks++;
    if (hit_cnt !== 16'(exp_h)) begin errors++; $display("FAIL stats_hits: got %0d expected %0d", hit_cnt, exp_h); end
    checks++;
    if (miss_cnt !== 16'(exp_m)) begin errors++; $display("FAIL stats_misses: got %0d expected %0d", miss_cnt, exp_m); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_miss();
    logic seen;
    do_load(10'h004, 0);
    cpu_rd = 1'b1; cpu_addr = 10'h084; seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (mem_rd) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL midreset_enter: mem_rd %b expected 1", seen); end
    rst_n = 1'b0; #1;
    checks++;
    if (mem_rd !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 10'h000) begin
      errors++; $display("FAIL midreset_drop: mem_rd %b stall %b addr %h expected 0 0 000", mem_rd, cpu_stall, mem_addr);
    end
    checks++;
    if (mem_err !== 1'b0 || hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      errors++; $display("FAIL midreset_clear: mem_err %b cnt %h/%h expected 0 0/0", mem_err, hit_cnt, miss_cnt);
    end
    @(posedge clk); #1; cpu_rd = 1'b0; cpu_addr = 10'h00C;
    @(negedge clk); rst_n = 1'b1;
    clear_model();
    @(posedge clk); #1; mem_ready = 1'b1; mem_rdata = block_of(10'h00C);
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL late_ready: mem_rd %b mem_wr %b stall %b expected 0 0 0", mem_rd, mem_wr, cpu_stall);
    end
    @(posedge clk); #1; mem_ready = 1'b0;
    do_load(10'h004, 0);
    do_load(10'h00C, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A5A_0000 + 32'(i) * 32'd7919;
    mem[10'h004] = 32'hDEAD_BEEF;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    clear_model();
    test_reset();
    test_read_miss_fill();
    test_store_hit();
    test_store_no_allocate();
    test_conflict();
    test_rd_wr_both();
    test_watchdog();
    test_random();
    test_stats();
    test_reset_mid_miss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
